// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: operand forwarding, ALU, branch
// target, destination select, and the EX/MEM pipeline register.
module execute_stage #(
  parameter int len         = 32,
  parameter int NB          = $clog2(len),
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [len-1:0]         in_pc_plus4,
  input  logic [len-1:0]         in_data_a,
  input  logic [len-1:0]         in_data_b,
  input  logic [len-1:0]         in_imm,
  input  logic [4:0]             in_shamt,
  input  logic [NB-1:0]          in_rs,
  input  logic [NB-1:0]          in_rt,
  input  logic [NB-1:0]          in_rd,
  input  logic [3:0]             in_alu_ctrl,
  input  logic                   in_alu_src,
  input  logic                   in_reg_dst,
  input  logic [len_mem_bus-1:0] in_memory_bus,
  input  logic [len_wb_bus-1:0]  in_writeBack_bus,
  input  logic                   in_halt_flag,
  input  logic [len-1:0]         fwd_exmem_data,
  input  logic [NB-1:0]          fwd_exmem_reg,
  input  logic                   fwd_exmem_regwrite,
  input  logic [len-1:0]         fwd_memwb_data,
  input  logic [NB-1:0]          fwd_memwb_reg,
  input  logic                   fwd_memwb_regwrite,
  output logic [len-1:0]         out_alu_result,
  output logic [len-1:0]         out_write_data,
  output logic [len_mem_bus-1:0] out_memory_bus,
  output logic [len_wb_bus-1:0]  out_writeBack_bus,
  output logic [NB-1:0]          out_write_reg,
  output logic                   zero_flag,
  output logic [len-1:0]         out_pc_branch,
  output logic                   out_halt_flag
);

  logic [len-1:0] fwd_a;
  logic [len-1:0] fwd_b;
  logic [len-1:0] op_b;
  logic [len-1:0] alu_result;
  logic [len-1:0] pc_branch;
  logic [NB-1:0]  write_reg;

  // Forwarding muxes: EX/MEM beats MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_a = in_data_a;
    if (fwd_exmem_regwrite && (fwd_exmem_reg != '0) && (fwd_exmem_reg == in_rs)) begin
      fwd_a = fwd_exmem_data;
    end else if (fwd_memwb_regwrite && (fwd_memwb_reg != '0) && (fwd_memwb_reg == in_rs)) begin
      fwd_a = fwd_memwb_data;
    end

    fwd_b = in_data_b;
    if (fwd_exmem_regwrite && (fwd_exmem_reg != '0) && (fwd_exmem_reg == in_rt)) begin
      fwd_b = fwd_exmem_data;
    end else if (fwd_memwb_regwrite && (fwd_memwb_reg != '0) && (fwd_memwb_reg == in_rt)) begin
      fwd_b = fwd_memwb_data;
    end
  end

  assign op_b = in_alu_src ? in_imm : fwd_b;

  // ALU; variable shifts use only the low five bits of operand A.
  always_comb begin
    alu_result = '0;
    unique case (in_alu_ctrl)
      4'd0:  alu_result = op_b << in_shamt;
      4'd1:  alu_result = op_b >> in_shamt;
      4'd2:  alu_result = $signed(op_b) >>> in_shamt;
      4'd3:  alu_result = op_b << fwd_a[4:0];
      4'd4:  alu_result = op_b >> fwd_a[4:0];
      4'd5:  alu_result = $signed(op_b) >>> fwd_a[4:0];
      4'd6:  alu_result = fwd_a + op_b;
      4'd7:  alu_result = fwd_a - op_b;
      4'd8:  alu_result = fwd_a & op_b;
      4'd9:  alu_result = fwd_a | op_b;
      4'd10: alu_result = fwd_a ^ op_b;
      4'd11: alu_result = ~(fwd_a | op_b);
      4'd12: alu_result = {{(len-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      4'd13: alu_result = in_imm << 16;
      4'd14: alu_result = {{(len-1){1'b0}}, (fwd_a < op_b)};
      4'd15: alu_result = fwd_a;
    endcase
  end

  assign pc_branch = in_pc_plus4 + (in_imm << 2);
  assign write_reg = in_reg_dst ? in_rd : in_rt;

  // EX/MEM register: flush bubbles even while stalled, otherwise load on enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_alu_result    <= '0;
      out_write_data    <= '0;
      out_memory_bus    <= '0;
      out_writeBack_bus <= '0;
      out_write_reg     <= '0;
      zero_flag         <= 1'b0;
      out_pc_branch     <= '0;
      out_halt_flag     <= 1'b0;
    end else if (flush) begin
      out_alu_result    <= '0;
      out_write_data    <= '0;
      out_memory_bus    <= '0;
      out_writeBack_bus <= '0;
      out_write_reg     <= '0;
      zero_flag         <= 1'b0;
      out_pc_branch     <= '0;
      out_halt_flag     <= 1'b0;
    end else if (enable) begin
      out_alu_result    <= alu_result;
      out_write_data    <= fwd_b;
      out_memory_bus    <= in_memory_bus;
      out_writeBack_bus <= in_writeBack_bus;
      out_write_reg     <= write_reg;
      zero_flag         <= (alu_result == '0);
      out_pc_branch     <= pc_branch;
      out_halt_flag     <= in_halt_flag;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        flush;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_data_a;
  logic [31:0] in_data_b;
  logic [31:0] in_imm;
  logic [4:0]  in_shamt;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [3:0]  in_alu_ctrl;
  logic        in_alu_src;
  logic        in_reg_dst;
  logic [8:0]  in_memory_bus;
  logic [1:0]  in_writeBack_bus;
  logic        in_halt_flag;
  logic [31:0] fwd_exmem_data;
  logic [4:0]  fwd_exmem_reg;
  logic        fwd_exmem_regwrite;
  logic [31:0] fwd_memwb_data;
  logic [4:0]  fwd_memwb_reg;
  logic        fwd_memwb_regwrite;
  logic [31:0] out_alu_result;
  logic [31:0] out_write_data;
  logic [8:0]  out_memory_bus;
  logic [1:0]  out_writeBack_bus;
  logic [4:0]  out_write_reg;
  logic        zero_flag;
  logic [31:0] out_pc_branch;
  logic        out_halt_flag;

  int checks;
  int failures;

  execute_stage dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .flush              (flush),
    .in_pc_plus4        (in_pc_plus4),
    .in_data_a          (in_data_a),
    .in_data_b          (in_data_b),
    .in_imm             (in_imm),
    .in_shamt           (in_shamt),
    .in_rs              (in_rs),
    .in_rt              (in_rt),
    .in_rd              (in_rd),
    .in_alu_ctrl        (in_alu_ctrl),
    .in_alu_src         (in_alu_src),
    .in_reg_dst         (in_reg_dst),
    .in_memory_bus      (in_memory_bus),
    .in_writeBack_bus   (in_writeBack_bus),
    .in_halt_flag       (in_halt_flag),
    .fwd_exmem_data     (fwd_exmem_data),
    .fwd_exmem_reg      (fwd_exmem_reg),
    .fwd_exmem_regwrite (fwd_exmem_regwrite),
    .fwd_memwb_data     (fwd_memwb_data),
    .fwd_memwb_reg      (fwd_memwb_reg),
    .fwd_memwb_regwrite (fwd_memwb_regwrite),
    .out_alu_result     (out_alu_result),
    .out_write_data     (out_write_data),
    .out_memory_bus     (out_memory_bus),
    .out_writeBack_bus  (out_writeBack_bus),
    .out_write_reg      (out_write_reg),
    .zero_flag          (zero_flag),
    .out_pc_branch      (out_pc_branch),
    .out_halt_flag      (out_halt_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_pc_plus4        = '0;
    in_data_a          = '0;
    in_data_b          = '0;
    in_imm             = '0;
    in_shamt           = '0;
    in_rs              = '0;
    in_rt              = '0;
    in_rd              = '0;
    in_alu_ctrl        = '0;
    in_alu_src         = 1'b0;
    in_reg_dst         = 1'b0;
    in_memory_bus      = '0;
    in_writeBack_bus   = '0;
    in_halt_flag       = 1'b0;
    fwd_exmem_data     = '0;
    fwd_exmem_reg      = '0;
    fwd_exmem_regwrite = 1'b0;
    fwd_memwb_data     = '0;
    fwd_memwb_reg      = '0;
    fwd_memwb_regwrite = 1'b0;
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    enable = 1'b1;
    flush  = 1'b0;
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({out_alu_result, out_write_data, out_memory_bus, out_writeBack_bus, out_write_reg,
         zero_flag, out_pc_branch, out_halt_flag} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: result=%h wdata=%h zero=%b pc=%h got nonzero, want 0",
               out_alu_result, out_write_data, zero_flag, out_pc_branch);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (zero_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_zero_before_capture: got %b want 0", zero_flag);
    end
    // All-zero inputs: SLL of 0 gives 0, so the first capture sets zero_flag.
    tick();
    checks++;
    if (zero_flag !== 1'b1 || out_alu_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_capture: zero=%b result=%h want 1/00000000",
               zero_flag, out_alu_result);
    end
  endtask

  task automatic test_add_sub;
    clear_inputs();
    in_data_a   = 32'd5;
    in_data_b   = 32'd7;
    in_rs       = 5'd1;
    in_rt       = 5'd2;
    in_rd       = 5'd3;
    in_reg_dst  = 1'b1;
    in_alu_ctrl = 4'd6;
    tick();
    checks++;
    if (out_alu_result !== 32'd12 || out_write_reg !== 5'd3 || zero_flag !== 1'b0 ||
        out_write_data !== 32'd7) begin
      failures++;
      $display("FAIL add: result=%0d reg=%0d zero=%b wdata=%0d want 12/3/0/7",
               out_alu_result, out_write_reg, zero_flag, out_write_data);
    end
    in_data_a   = 32'd9;
    in_data_b   = 32'd9;
    in_alu_ctrl = 4'd7;
    in_reg_dst  = 1'b0;
    tick();
    checks++;
    if (out_alu_result !== 32'd0 || zero_flag !== 1'b1 || out_write_reg !== 5'd2) begin
      failures++;
      $display("FAIL sub_zero: result=%0d zero=%b reg=%0d want 0/1/2",
               out_alu_result, zero_flag, out_write_reg);
    end
  endtask

  task automatic test_forwarding;
    clear_inputs();
    in_alu_ctrl        = 4'd6;
    in_rs              = 5'd4;
    in_rt              = 5'd5;
    in_data_a          = 32'd50;
    in_data_b          = 32'd1;
    fwd_exmem_reg      = 5'd4;
    fwd_exmem_regwrite = 1'b1;
    fwd_exmem_data     = 32'd100;
    fwd_memwb_reg      = 5'd4;
    fwd_memwb_regwrite = 1'b1;
    fwd_memwb_data     = 32'd200;
    tick();
    checks++;
    if (out_alu_result !== 32'd101) begin
      failures++;
      $display("FAIL fwd_exmem_priority: got %0d want 101", out_alu_result);
    end
    fwd_exmem_regwrite = 1'b0;
    tick();
    checks++;
    if (out_alu_result !== 32'd201) begin
      failures++;
      $display("FAIL fwd_memwb: got %0d want 201", out_alu_result);
    end
    in_rs              = 5'd0;
    fwd_exmem_reg      = 5'd0;
    fwd_exmem_regwrite = 1'b1;
    fwd_memwb_reg      = 5'd0;
    tick();
    checks++;
    if (out_alu_result !== 32'd51) begin
      failures++;
      $display("FAIL fwd_reg0: got %0d want 51", out_alu_result);
    end
    // Operand B forwarded from MEM/WB into both the ALU and the store data.
    in_rs          = 5'd1;
    in_rt          = 5'd6;
    fwd_exmem_reg  = 5'd9;
    fwd_memwb_reg  = 5'd6;
    tick();
    checks++;
    if (out_alu_result !== 32'd250 || out_write_data !== 32'd200) begin
      failures++;
      $display("FAIL fwd_b: result=%0d wdata=%0d want 250/200", out_alu_result, out_write_data);
    end
  endtask

  task automatic test_shift_compare;
    clear_inputs();
    in_data_b   = 32'h8000_0000;
    in_shamt    = 5'd4;
    in_alu_ctrl = 4'd2;
    tick();
    checks++;
    if (out_alu_result !== 32'hF800_0000) begin
      failures++;
      $display("FAIL sra: got %h want f8000000", out_alu_result);
    end
    in_alu_ctrl = 4'd1;
    tick();
    checks++;
    if (out_alu_result !== 32'h0800_0000) begin
      failures++;
      $display("FAIL srl: got %h want 08000000", out_alu_result);
    end
    in_alu_ctrl = 4'd5;
    in_data_a   = 32'd36;
    tick();
    checks++;
    if (out_alu_result !== 32'hF800_0000) begin
      failures++;
      $display("FAIL srav: got %h want f8000000", out_alu_result);
    end
    in_alu_ctrl = 4'd3;
    in_data_a   = 32'd8;
    in_data_b   = 32'd1;
    tick();
    checks++;
    if (out_alu_result !== 32'd256) begin
      failures++;
      $display("FAIL sllv: got %h want 00000100", out_alu_result);
    end
    in_alu_ctrl = 4'd12;
    in_data_a   = 32'hFFFF_FFFF;
    in_data_b   = 32'd1;
    tick();
    checks++;
    if (out_alu_result !== 32'd1) begin
      failures++;
      $display("FAIL slt: got %h want 00000001", out_alu_result);
    end
    in_alu_ctrl = 4'd14;
    tick();
    checks++;
    if (out_alu_result !== 32'd0 || zero_flag !== 1'b1) begin
      failures++;
      $display("FAIL sltu: result=%h zero=%b want 00000000/1", out_alu_result, zero_flag);
    end
    in_alu_ctrl = 4'd13;
    in_imm      = 32'h0000_1234;
    tick();
    checks++;
    if (out_alu_result !== 32'h1234_0000) begin
      failures++;
      $display("FAIL lui: got %h want 12340000", out_alu_result);
    end
    in_alu_ctrl = 4'd11;
    in_data_a   = 32'h0F0F_0000;
    in_data_b   = 32'h0000_00F0;
    tick();
    checks++;
    if (out_alu_result !== 32'hF0F0_FF0F) begin
      failures++;
      $display("FAIL nor: got %h want f0f0ff0f", out_alu_result);
    end
  endtask

  task automatic test_branch_store;
    clear_inputs();
    in_pc_plus4 = 32'h40;
    in_imm      = 32'hFFFF_FFFE;
    in_alu_ctrl = 4'd7;
    tick();
    checks++;
    if (out_pc_branch !== 32'h38) begin
      failures++;
      $display("FAIL branch_target: got %h want 00000038", out_pc_branch);
    end
    clear_inputs();
    in_alu_ctrl      = 4'd6;
    in_alu_src       = 1'b1;
    in_imm           = 32'd8;
    in_data_a        = 32'd16;
    in_data_b        = 32'h1111;
    in_rs            = 5'd2;
    in_rt            = 5'd7;
    fwd_memwb_reg    = 5'd7;
    fwd_memwb_regwrite = 1'b1;
    fwd_memwb_data   = 32'hABCD;
    in_memory_bus    = 9'h1A5;
    in_writeBack_bus = 2'b10;
    in_halt_flag     = 1'b1;
    tick();
    checks++;
    if (out_alu_result !== 32'd24 || out_write_data !== 32'hABCD || out_write_reg !== 5'd7) begin
      failures++;
      $display("FAIL store: result=%0d wdata=%h reg=%0d want 24/abcd/7",
               out_alu_result, out_write_data, out_write_reg);
    end
    checks++;
    if (out_memory_bus !== 9'h1A5 || out_writeBack_bus !== 2'b10 || out_halt_flag !== 1'b1) begin
      failures++;
      $display("FAIL passthrough: mem=%h wb=%b halt=%b want 1a5/10/1",
               out_memory_bus, out_writeBack_bus, out_halt_flag);
    end
  endtask

  // Entered with the store result (24) captured in EX/MEM.
  task automatic test_stall_flush;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data_a   = 32'd1000 + i;
      in_alu_ctrl = 4'd9;
      in_rt       = 5'(i + 10);
      tick();
      checks++;
      if (out_alu_result !== 32'd24 || out_write_reg !== 5'd7 || out_halt_flag !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold_%0d: result=%0d reg=%0d halt=%b want 24/7/1",
                 i, out_alu_result, out_write_reg, out_halt_flag);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (out_alu_result !== '0 || out_write_data !== '0 || out_memory_bus !== '0 ||
        out_writeBack_bus !== '0 || out_write_reg !== '0 || out_halt_flag !== 1'b0 ||
        zero_flag !== 1'b0 || out_pc_branch !== '0) begin
      failures++;
      $display("FAIL flush_stalled: result=%h mem=%h halt=%b want all 0",
               out_alu_result, out_memory_bus, out_halt_flag);
    end
    flush  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_async_reset;
    clear_inputs();
    in_data_a     = 32'd3;
    in_data_b     = 32'd4;
    in_alu_ctrl   = 4'd6;
    in_memory_bus = 9'h0FF;
    tick();
    checks++;
    if (out_alu_result !== 32'd7) begin
      failures++;
      $display("FAIL preload: got %0d want 7", out_alu_result);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_alu_result !== '0 || out_memory_bus !== '0 || out_write_data !== '0) begin
      failures++;
      $display("FAIL async_reset: result=%0d mem=%h wdata=%0d want 0",
               out_alu_result, out_memory_bus, out_write_data);
    end
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    checks++;
    if (out_alu_result !== '0) begin
      failures++;
      $display("FAIL post_reset_stall: got %0d want 0", out_alu_result);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (out_alu_result !== 32'd7 || out_memory_bus !== 9'h0FF) begin
      failures++;
      $display("FAIL post_reset_capture: result=%0d mem=%h want 7/0ff",
               out_alu_result, out_memory_bus);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_sub();
    test_forwarding();
    test_shift_compare();
    test_branch_store();
    test_stall_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline. It sits between the ID/EX register and the memory stage.
- It performs operand forwarding, operand selection, the ALU operation, branch-target computation and destination-register selection.
- It registers the results into the EX/MEM pipeline register. The memory stage consumes that register: ALU result as address, store data, memory/WB control buses, zero flag, branch target and halt flag.

Parameters:
- len, 32, datapath width.
- NB, $clog2(len), register-index width.
- len_mem_bus, 9, memory-stage control bus width (passed through unmodified).
- len_wb_bus, 2, write-back control bus width (passed through; bit 0 = RegWrite).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  pipeline advance; low = hold all registers (stall / debug step).
- flush  input  1  insert bubble into EX/MEM.
- in_pc_plus4  input  len  PC+4 of the instruction.
- in_data_a  input  len  rs value from register file.
- in_data_b  input  len  rt value from register file.
- in_imm  input  len  sign-extended immediate.
- in_shamt  input  5  shift amount field.
- in_rs, in_rt, in_rd  input  NB  register indices.
- in_alu_ctrl  input  4  ALU operation code.
- in_alu_src  input  1  1 = operand B is in_imm.
- in_reg_dst  input  1  1 = destination rd, 0 = rt.
- in_memory_bus  input  len_mem_bus  memory control, passthrough.
- in_writeBack_bus  input  len_wb_bus  WB control, passthrough.
- in_halt_flag  input  1  halt marker.
- fwd_exmem_data  input  len  ALU result held in EX/MEM (the memory stage's address input).
- fwd_exmem_reg  input  NB  destination held in EX/MEM.
- fwd_exmem_regwrite  input  1  RegWrite held in EX/MEM.
- fwd_memwb_data  input  len  final write-back value.
- fwd_memwb_reg  input  NB  destination in MEM/WB.
- fwd_memwb_regwrite  input  1  RegWrite in MEM/WB.
- out_alu_result  output  len  registered ALU result / memory address.
- out_write_data  output  len  registered forwarded rt value (store data).
- out_memory_bus  output  len_mem_bus  registered.
- out_writeBack_bus  output  len_wb_bus  registered.
- out_write_reg  output  NB  registered destination register.
- zero_flag  output  1  registered, 1 when the ALU result is 0.
- out_pc_branch  output  len  registered branch target.
- out_halt_flag  output  1  registered.

Behaviour:
- Reset (reset=0, asynchronous): every output register is 0.
- Forwarding, combinational, per operand (A uses in_rs, B uses in_rt):
  - EX/MEM is selected if its regwrite=1, its reg!=0 and its reg matches the operand index.
  - Otherwise MEM/WB is selected under the same conditions.
  - Otherwise the register-file value is used.
  - EX/MEM has priority when both match. Register 0 is never forwarded.
- Operand selection: opB = in_alu_src ? in_imm : fwdB. out_write_data always takes fwdB, never the immediate.
- in_alu_ctrl encoding:
  - 0 SLL: opB<<shamt.
  - 1 SRL: opB>>shamt, logical.
  - 2 SRA: opB>>>shamt, arithmetic.
  - 3 SLLV: opB<<fwdA[4:0].
  - 4 SRLV: opB>>fwdA[4:0], logical.
  - 5 SRAV: opB>>>fwdA[4:0], arithmetic.
  - 6 ADD, 7 SUB: modulo 2^len, no overflow trap.
  - 8 AND, 9 OR, 10 XOR, 11 NOR.
  - 12 SLT: signed, result 0/1.
  - 13 LUI: {imm[15:0],16'h0}.
  - 14 SLTU: unsigned, result 0/1.
  - 15 pass opA.
- Branch target: in_pc_plus4 + (in_imm<<2), wraps modulo 2^len.
- Destination register: in_reg_dst ? in_rd : in_rt.
- Register update, single-cycle latency, priority order:
  - flush=1 (regardless of enable): bubble. All outputs 0.
  - else enable=0: all outputs hold.
  - else: all outputs load the new values.
- zero_flag is computed from the same ALU result that loads out_alu_result. Decode issues SUB for BEQ/BNE, so the memory stage's pc_src is correct.
- Halt: in_halt_flag is passed through like the control buses; a flush clears it.
- Reset asserted mid-operation: immediate clear. The first capture after release is on the first rising edge with enable=1.

Test Plan:
- Reset low then release, enable=1, no inputs driven → all outputs 0; zero_flag=0 until the first capture.
- ADD: a=5, b=7, alu_src=0, rd=3, reg_dst=1 → next edge: out_alu_result=12, out_write_reg=3, zero_flag=0. SUB with a=b=9 → result 0, zero_flag=1.
- Forwarding priority: rs=4, exmem reg=4 regwrite=1 data=100, memwb reg=4 data=200, b=1, ADD → result 101. Exmem reg=0 with rs=0 → register-file value used.
- SRA a=x, b=32'h80000000, shamt=4 → 32'hF8000000. SLT -1 vs 1 → 1. SLTU -1 vs 1 → 0.
- Branch: pc_plus4=32'h40, imm=-2 → out_pc_branch=32'h38. Store: alu_src=1, imm=8, a=16, fwd b=32'hABCD → result 24, write_data 32'hABCD.
- Stall and flush:
  - enable=0 for 3 cycles while inputs change → outputs hold.
  - flush=1 with enable=0 → all outputs 0 on the next edge.
  - Reset pulse mid-stream → outputs clear asynchronously, before any clock edge.
